// File: rtl/ft_slv_pkg.sv
// Shared widths, flag-limiter state encoding and error bit positions for the
// FT600 245-mode chip-side model.
package ft_slv_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int WORD_W = DATA_W + BE_W;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_GAP    = 1'b1
  } flag_st_e;

  localparam int ERR_TX_OVF  = 0;
  localparam int ERR_WR_BUSY = 1;
  localparam int ERR_RD_BUSY = 2;
  localparam int ERR_W       = 3;

endpackage

// File: rtl/ft_slv_sync_fifo.sv
// First-word-fall-through synchronous FIFO with current and next-state counts.
// Push while full and pop while empty are ignored.
module ft_slv_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic [AW:0]  cnt_o,
  output logic [AW:0]  cnt_nxt_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: it is only visible through a non-zero count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  assign dout_o    = mem_q[rptr_q];
  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/ft_slv_fifo_model.sv
// Chip side of the FT600 245-mode synchronous FIFO bus: two direction buffers,
// registered txe_n/rxf_n flags with a per-direction burst limiter, sticky errors.
module ft_slv_fifo_model
  import ft_slv_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int BURST_MAX = 8,
  parameter int GAP       = 3
) (
  input  logic              clk,
  input  logic              rst,
  output logic              txe_n,
  output logic              rxf_n,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic              oe_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [DATA_W-1:0] data_o,
  output logic [BE_W-1:0]   be_o,
  output logic              data_oe,
  input  logic              tx_wr,
  input  logic [WORD_W-1:0] tx_din,
  output logic              tx_full,
  input  logic              rx_rd,
  output logic [WORD_W-1:0] rx_dout,
  output logic              rx_empty,
  output logic [AW:0]       rx_cnt,
  output logic [ERR_W-1:0]  err
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  logic [WORD_W-1:0] tx_head;
  logic              tx_empty;
  logic [AW:0]       tx_cnt, tx_cnt_nxt, rx_cnt_nxt;
  logic              rd_pop, wr_acc;

  flag_st_e          rstate_q, rstate_d, wstate_q, wstate_d;
  logic [BW-1:0]     rbcnt_q, rbcnt_d, wbcnt_q, wbcnt_d;
  logic [GW-1:0]     rgcnt_q, rgcnt_d, wgcnt_q, wgcnt_d;
  logic              rxf_n_q, rxf_n_d, txe_n_q, txe_n_d;
  logic              data_oe_q;
  logic [ERR_W-1:0]  err_q, err_d;

  // A registered flag low guarantees the matching buffer can take the transfer.
  assign rd_pop = ~rd_n & ~oe_n & ~rxf_n_q;
  assign wr_acc = ~wr_n & ~txe_n_q;

  ft_slv_sync_fifo #(.DEPTH(DEPTH), .AW(AW), .W(WORD_W)) u_txbuf (
    .clk       (clk),
    .rst       (rst),
    .push_i    (tx_wr),
    .din_i     (tx_din),
    .pop_i     (rd_pop),
    .dout_o    (tx_head),
    .empty_o   (tx_empty),
    .cnt_o     (tx_cnt),
    .cnt_nxt_o (tx_cnt_nxt)
  );

  ft_slv_sync_fifo #(.DEPTH(DEPTH), .AW(AW), .W(WORD_W)) u_rxbuf (
    .clk       (clk),
    .rst       (rst),
    .push_i    (wr_acc),
    .din_i     ({be_i, data_i}),
    .pop_i     (rx_rd),
    .dout_o    (rx_dout),
    .empty_o   (rx_empty),
    .cnt_o     (rx_cnt),
    .cnt_nxt_o (rx_cnt_nxt)
  );

  // Read-direction burst limiter.
  always_comb begin
    rstate_d = rstate_q;
    rbcnt_d  = rbcnt_q;
    rgcnt_d  = rgcnt_q;
    case (rstate_q)
      ST_ACTIVE: begin
        if (rd_n) begin
          rbcnt_d = '0;
        end else if (rd_pop) begin
          if (rbcnt_q == BW'(BURST_MAX - 1)) begin
            rstate_d = ST_GAP;
            rbcnt_d  = '0;
            rgcnt_d  = '0;
          end else begin
            rbcnt_d = rbcnt_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        rbcnt_d = '0;
        if (rgcnt_q == GW'(GAP - 1)) rstate_d = ST_ACTIVE;
        else                         rgcnt_d  = rgcnt_q + 1'b1;
      end
      default: rstate_d = ST_ACTIVE;
    endcase
  end

  // Write-direction burst limiter.
  always_comb begin
    wstate_d = wstate_q;
    wbcnt_d  = wbcnt_q;
    wgcnt_d  = wgcnt_q;
    case (wstate_q)
      ST_ACTIVE: begin
        if (wr_n) begin
          wbcnt_d = '0;
        end else if (wr_acc) begin
          if (wbcnt_q == BW'(BURST_MAX - 1)) begin
            wstate_d = ST_GAP;
            wbcnt_d  = '0;
            wgcnt_d  = '0;
          end else begin
            wbcnt_d = wbcnt_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        wbcnt_d = '0;
        if (wgcnt_q == GW'(GAP - 1)) wstate_d = ST_ACTIVE;
        else                         wgcnt_d  = wgcnt_q + 1'b1;
      end
      default: wstate_d = ST_ACTIVE;
    endcase
  end

  // Flags come from next-state occupancy so they go inactive right after the
  // last word/slot is used, without a cycle of over-run.
  always_comb begin
    rxf_n_d = (tx_cnt_nxt == '0) | (rstate_d == ST_GAP);
    txe_n_d = (rx_cnt_nxt == (AW+1)'(DEPTH)) | (wstate_d == ST_GAP);
    err_d   = err_q;
    if (tx_wr & tx_full)          err_d[ERR_TX_OVF]  = 1'b1;
    if (~wr_n & txe_n_q)          err_d[ERR_WR_BUSY] = 1'b1;
    if (~rd_n & ~oe_n & rxf_n_q)  err_d[ERR_RD_BUSY] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q  <= ST_ACTIVE;
      wstate_q  <= ST_ACTIVE;
      rbcnt_q   <= '0;
      wbcnt_q   <= '0;
      rgcnt_q   <= '0;
      wgcnt_q   <= '0;
      rxf_n_q   <= 1'b1;
      txe_n_q   <= 1'b1;
      data_oe_q <= 1'b0;
      err_q     <= '0;
    end else begin
      rstate_q  <= rstate_d;
      wstate_q  <= wstate_d;
      rbcnt_q   <= rbcnt_d;
      wbcnt_q   <= wbcnt_d;
      rgcnt_q   <= rgcnt_d;
      wgcnt_q   <= wgcnt_d;
      rxf_n_q   <= rxf_n_d;
      txe_n_q   <= txe_n_d;
      data_oe_q <= ~oe_n;
      err_q     <= err_d;
    end
  end

  assign {be_o, data_o} = tx_empty ? {WORD_W{1'b1}} : tx_head;
  assign tx_full        = (tx_cnt == (AW+1)'(DEPTH));
  assign rxf_n          = rxf_n_q;
  assign txe_n          = txe_n_q;
  assign data_oe        = data_oe_q;
  assign err            = err_q;

endmodule

// File: tb/tb_ft_slv_fifo_model.sv
// Bench for ft_slv_fifo_model: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ft_slv_fifo_model;

  localparam int DEPTH = 16, AW = 4, BURST_MAX = 8, GAP = 3;

  logic        clk = 1'b0, rst = 1'b1;
  logic        txe_n, rxf_n, data_oe, tx_full, rx_empty;
  logic        wr_n = 1'b1, rd_n = 1'b1, oe_n = 1'b1, tx_wr = 1'b0, rx_rd = 1'b0;
  logic [31:0] data_i = '0, data_o;
  logic [3:0]  be_i = '0, be_o;
  logic [35:0] tx_din = '0, rx_dout;
  logic [AW:0] rx_cnt;
  logic [2:0]  err;

  always #5 clk = ~clk;

  ft_slv_fifo_model #(.DEPTH(DEPTH), .AW(AW), .BURST_MAX(BURST_MAX), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .txe_n(txe_n), .rxf_n(rxf_n), .wr_n(wr_n), .rd_n(rd_n),
    .oe_n(oe_n), .data_i(data_i), .be_i(be_i), .data_o(data_o), .be_o(be_o),
    .data_oe(data_oe), .tx_wr(tx_wr), .tx_din(tx_din), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_dout(rx_dout), .rx_empty(rx_empty), .rx_cnt(rx_cnt), .err(err)
  );

  int n_tests = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: buffers as queues, gap as a remaining-cycles count.
  logic [35:0] m_txq[$], m_rxq[$];
  bit          m_rxf_n = 1, m_txe_n = 1, m_oe = 0;
  logic [2:0]  m_err = '0;
  int          m_rrun = 0, m_rgap = 0, m_wrun = 0, m_wgap = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_txq.delete(); m_rxq.delete();
      m_rxf_n = 1; m_txe_n = 1; m_oe = 0; m_err = '0;
      m_rrun = 0; m_rgap = 0; m_wrun = 0; m_wgap = 0;
    end else begin
      bit rdx, wrx;
      rdx = !rd_n && !oe_n && !m_rxf_n;
      wrx = !wr_n && !m_txe_n;
      if (!rd_n && !oe_n && m_rxf_n) m_err[2] = 1'b1;
      if (!wr_n && m_txe_n)          m_err[1] = 1'b1;
      if (tx_wr && m_txq.size() == DEPTH) m_err[0] = 1'b1;
      if (tx_wr && m_txq.size() < DEPTH) begin
        if (rdx) void'(m_txq.pop_front());
        m_txq.push_back(tx_din);
      end else if (rdx) void'(m_txq.pop_front());
      if (rx_rd && m_rxq.size() > 0) void'(m_rxq.pop_front());
      if (wrx) m_rxq.push_back({be_i, data_i});
      if (m_rgap > 0) m_rgap--;
      if (rd_n) m_rrun = 0;
      else if (rdx) begin
        m_rrun++;
        if (m_rrun == BURST_MAX) begin m_rrun = 0; m_rgap = GAP; end
      end
      if (m_wgap > 0) m_wgap--;
      if (wr_n) m_wrun = 0;
      else if (wrx) begin
        m_wrun++;
        if (m_wrun == BURST_MAX) begin m_wrun = 0; m_wgap = GAP; end
      end
      m_rxf_n = (m_txq.size() == 0) || (m_rgap > 0);
      m_txe_n = (m_rxq.size() == DEPTH) || (m_wgap > 0);
      m_oe    = !oe_n;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rxf_n", rxf_n, m_rxf_n);
      chk("txe_n", txe_n, m_txe_n);
      chk("data_oe", data_oe, m_oe);
      chk("data_o", {be_o, data_o}, (m_txq.size() > 0) ? m_txq[0] : 36'hF_FFFF_FFFF);
      chk("tx_full", tx_full, m_txq.size() == DEPTH);
      chk("rx_empty", rx_empty, m_rxq.size() == 0);
      chk("rx_cnt", rx_cnt, m_rxq.size());
      if (m_rxq.size() > 0) chk("rx_dout", rx_dout, m_rxq[0]);
      chk("err", err, m_err);
    end
  end

  task automatic cyc(); @(negedge clk); endtask
  task automatic idle();
    tx_wr = 0; rx_rd = 0; rd_n = 1; oe_n = 1; wr_n = 1;
  endtask
  task automatic do_reset();
    rst = 1; idle(); cyc(); cyc(); rst = 0;
  endtask

  function automatic bit exp_s2(input int c);
    return (c >= 8 && c <= 10) || (c >= 19 && c <= 21) || (c >= 26);
  endfunction

  initial begin
    logic [35:0] got[$];
    logic [35:0] w;
    bit          tlog[40];
    bit          acc;
    int          k, c, pushed;

    // Reset state
    do_reset();
    chk_en = 1;
    chk("rst_txe_n", txe_n, 1); chk("rst_rxf_n", rxf_n, 1);
    chk("rst_data_o", {be_o, data_o}, 36'hF_FFFF_FFFF); chk("rst_oe", data_oe, 0);
    chk("rst_tx_full", tx_full, 0); chk("rst_rx_empty", rx_empty, 1);
    chk("rst_rx_cnt", rx_cnt, 0); chk("rst_err", err, 0);

    // S1: 3 words pushed then read
    for (int i = 0; i < 3; i++) begin
      tx_wr = 1; tx_din = 36'hF_A000_0000 + 36'(i);
      if (i == 0) chk("s1_rxf_push", rxf_n, 1);
      cyc();
      if (i == 0) chk("s1_rxf_2nd", rxf_n, 0);
    end
    tx_wr = 0; rd_n = 0; oe_n = 0;
    for (int i = 0; i < 3; i++) begin
      chk("s1_rd", {be_o, data_o}, 36'hF_A000_0000 + 36'(i));
      chk("s1_oe", data_oe, i > 0);
      cyc();
    end
    rd_n = 1; oe_n = 1;
    chk("s1_rxf_after", rxf_n, 1); chk("s1_err", err, 0);
    cyc();

    // S2: 20 words through the read burst limiter
    do_reset();
    for (int i = 0; i < 16; i++) begin tx_wr = 1; tx_din = 36'h5_B000_0000 + 36'(i); cyc(); end
    tx_wr = 0; pushed = 16; got.delete();
    rd_n = 0; oe_n = 0;
    for (c = 0; c < 30; c++) begin
      chk("s2_rxf_pattern", rxf_n, exp_s2(c));
      if (!rxf_n) got.push_back({be_o, data_o});
      tx_wr = (pushed < 20) && !tx_full;
      tx_din = 36'h5_B000_0000 + 36'(pushed);
      if (tx_wr) pushed++;
      cyc();
    end
    idle();
    chk("s2_count", got.size(), 20);
    for (int i = 0; i < got.size(); i++) chk("s2_order", got[i], 36'h5_B000_0000 + 36'(i));
    chk("s2_err", err, 3'b100);
    cyc();

    // S3: master writes 16 words into an empty model
    do_reset();
    k = 0; c = 0;
    while (k < 16 && c < 40) begin
      tlog[c] = txe_n;
      acc = !txe_n;
      wr_n = txe_n; data_i = 32'hC000_0000 + 32'(k); be_i = (k == 15) ? 4'h3 : 4'hF;
      cyc();
      if (acc) k++;
      c++;
    end
    wr_n = 1;
    chk("s3_done", k, 16);
    chk("s3_txe_c0", tlog[0], 1); chk("s3_txe_c8", tlog[8], 0);
    chk("s3_gap_a", tlog[9], 1); chk("s3_gap_b", tlog[10], 1); chk("s3_gap_c", tlog[11], 1);
    chk("s3_txe_c12", tlog[12], 0); chk("s3_cycles", c, 20);
    for (int i = 0; i < 4; i++) begin
      chk("s3_full_txe", txe_n, 1); chk("s3_full_cnt", rx_cnt, 16);
      cyc();
    end
    chk("s3_err", err, 0);

    // S4: host pop and master write at the same edge while full
    wr_n = 0; data_i = 32'hDEAD_BEEF; be_i = 4'hF; rx_rd = 1;
    cyc();
    wr_n = 1; rx_rd = 0;
    chk("s4_txe_fall", txe_n, 0); chk("s4_err", err, 3'b010); chk("s4_cnt", rx_cnt, 15);
    for (int i = 1; i < 16; i++) begin
      w = {(i == 15) ? 4'h3 : 4'hF, 32'hC000_0000 + 32'(i)};
      chk("s4_rx_dout", rx_dout, w);
      rx_rd = 1; cyc();
    end
    rx_rd = 0;
    chk("s4_empty", rx_empty, 1);
    cyc();

    // S5: push while full is dropped, stream stays intact
    do_reset();
    for (int i = 0; i < 16; i++) begin tx_wr = 1; tx_din = 36'h9_D000_0000 + 36'(i); cyc(); end
    tx_din = 36'h0_EEEE_EEEE;
    chk("s5_full", tx_full, 1);
    cyc();
    tx_wr = 0;
    chk("s5_err", err, 3'b001);
    got.delete(); rd_n = 0; oe_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!rxf_n) got.push_back({be_o, data_o});
      cyc();
    end
    idle();
    chk("s5_count", got.size(), 16);
    for (int i = 0; i < got.size(); i++) chk("s5_order", got[i], 36'h9_D000_0000 + 36'(i));
    cyc();

    // S6: reset in the middle of a read burst
    do_reset();
    for (int i = 0; i < 5; i++) begin tx_wr = 1; tx_din = 36'h1_F000_0000 + 36'(i); cyc(); end
    tx_wr = 0; rd_n = 0; oe_n = 0;
    cyc(); cyc();
    rst = 1;
    cyc();
    rst = 0; rd_n = 1; oe_n = 1;
    chk("s6_rxf", rxf_n, 1); chk("s6_oe", data_oe, 0);
    chk("s6_data", {be_o, data_o}, 36'hF_FFFF_FFFF); chk("s6_full", tx_full, 0);
    tx_wr = 1; tx_din = 36'h2_0000_0A00; cyc();
    tx_din = 36'h2_0000_0A01; cyc();
    tx_wr = 0; rd_n = 0; oe_n = 0;
    chk("s6_x0", {be_o, data_o}, 36'h2_0000_0A00); cyc();
    chk("s6_x1", {be_o, data_o}, 36'h2_0000_0A01);
    idle(); cyc();

    // Randomized traffic, polite and rude masters alternating
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int i = 0; i < 600; i++) begin
        rst    = ($urandom_range(0, 249) == 0);
        tx_wr  = ($urandom_range(0, 2) != 0);
        tx_din = {4'($urandom), 32'($urandom)};
        rx_rd  = ($urandom_range(0, 7) <= seg);
        data_i = $urandom; be_i = 4'($urandom);
        if (seg % 2 == 1) begin
          rd_n = rxf_n | ($urandom_range(0, 7) == 0);
          oe_n = rd_n & ($urandom_range(0, 1) == 0);
          wr_n = txe_n | ($urandom_range(0, 5) == 0);
        end else begin
          rd_n = ($urandom_range(0, 3) == 0);
          oe_n = ($urandom_range(0, 4) == 0);
          wr_n = ($urandom_range(0, 3) == 0);
        end
        cyc();
      end
    end
    rst = 0; idle(); cyc(); cyc();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ft_slv_fifo_model.md
Name: ft_slv_fifo_model

Overview:
- Synthesizable model of the FT600 chip side of the 245-mode (single-channel) synchronous FIFO bus, responding to mst_fifo_fsm.
- Drives txe_n and rxf_n. Sources read data on oe_n/rd_n. Sinks write data on wr_n.
- Sits in the loopback/self-test build in place of the physical FT600. A host-side push/pop port lets bench or on-chip generator logic fill the chip-to-FPGA buffer and drain the FPGA-to-chip buffer.
- Exercises the master's burst termination, remain-data and re-arbitration paths.

Parameters:
DEPTH, 16, words per direction buffer (power of 2, >=4)
AW, 4, log2(DEPTH)
BURST_MAX, 8, max words per burst before the flag is forced inactive
GAP, 3, cycles the flag is held inactive after a burst limit hit (>=1)

Ports:
clk  in  1  bus clock
rst  in  1  synchronous reset, active-high
txe_n  out  1  0 = model can accept a write word
rxf_n  out  1  0 = model holds a word for the master
wr_n  in  1  master write strobe
rd_n  in  1  master read strobe
oe_n  in  1  master output-enable request
data_i  in  32  bus data from master
be_i  in  4  byte enables from master
data_o  out  32  bus data to master
be_o  out  4  byte enables to master
data_oe  out  1  model drives data_o/be_o
tx_wr  in  1  host push into chip-to-FPGA buffer
tx_din  in  36  {be,data} pushed
tx_full  out  1  chip-to-FPGA buffer full
rx_rd  in  1  host pop from FPGA-to-chip buffer
rx_dout  out  36  {be,data} head word, first-word-fall-through
rx_empty  out  1  FPGA-to-chip buffer empty
rx_cnt  out  AW+1  FPGA-to-chip occupancy
err  out  3  sticky: [0] tx_wr while full, [1] wr_n low while txe_n high, [2] rd_n low while rxf_n high

Behaviour:
- Reset (rst high at a clk edge):
  - Both buffers are emptied and all counters clear.
  - Outputs: txe_n=1, rxf_n=1, data_oe=0, data_o=32'hFFFF_FFFF, be_o=4'hF, tx_full=0, rx_empty=1, rx_cnt=0, err=0.
  - A reset asserted mid-burst discards the burst with no partial accept.
- Read side (chip to FPGA):
  - A pop occurs when rd_n=0, oe_n=0 and rxf_n=0 are all sampled at the same edge.
  - data_o/be_o is the head word (combinational FWFT) whenever the buffer is non-empty, otherwise FFFF_FFFF/F. It advances on the edge after a pop.
  - data_oe is a registered copy of ~oe_n, giving 1 cycle latency.
- Write side (FPGA to chip): an accept occurs when wr_n=0 and txe_n=0 at the same edge; {be_i,data_i} is stored. be_i is stored verbatim, including partial enables.
- Flags are registered from the next-state occupancy:
  - rxf_n = (next tx count == 0) or rgap_active.
  - txe_n = (next rx free == 0) or wgap_active.
  - The flag is therefore already 1 in the cycle after the last word is consumed or the last free slot is filled.
- Burst limiter, per direction, with state machine ACTIVE -> GAP -> ACTIVE:
  - The burst counter increments on each transfer and clears when the strobe is sampled high.
  - On the BURST_MAX-th consecutive transfer, enter GAP. The flag is forced to 1 for exactly GAP cycles, then the FSM returns to ACTIVE.
  - Strobes sampled during GAP transfer nothing.
- Host push and chip pop in the same cycle: count unchanged, both take effect.
- Host pop and chip accept in the same cycle: the same rule applies.
- tx_wr while full is dropped and sets err[0].
- rx_rd while empty is ignored, with no error.
- Strobes sampled low while the corresponding flag is high transfer nothing and set err[1] or err[2]. err bits clear only on rst.
- rd_n=0 with oe_n=1 transfers nothing and raises no error.
- Pointers wrap modulo DEPTH. Occupancy uses AW+1 bits, so full is count==DEPTH.

Decomposition:
- Package ft_slv_pkg holds: DATA_W=32, BE_W=4, WORD_W=36, the flag FSM state encoding {ACTIVE, GAP}, and the error bit indices.
- One sub-module, ft_slv_sync_fifo (FWFT, count output, DEPTH/AW parameters), instantiated twice.
- The burst limiter is kept inline, duplicated per direction.

Test Plan:
- Reset, then push 3 words (A0..A2): rxf_n=0 on the 2nd cycle after the first push. Master reads with oe_n/rd_n low for 3 cycles and gets A0, A1, A2. rxf_n=1 in the cycle after A2 is popped, err=0.
- Push 20 words and hold rd_n=oe_n=0 with BURST_MAX=8, GAP=3:
  - 8 words, then rxf_n=1 for 3 cycles, then 8 words, a gap, then 4 words.
  - Order is preserved and err[2] is set by the strobes held during the gaps.
- Master writes 16 words with be 4'hF, the last with be 4'h3, into an empty model:
  - txe_n=1 after the 8th accept for 3 cycles.
  - rx_cnt reaches 16 and txe_n stays 1 while full.
  - rx_dout shows every word, the last as {4'h3,data}.
- With the rx buffer full and rx_rd pulsed once at the same edge wr_n is low: the word is not accepted and err[1]=1. txe_n falls the following cycle.
- tx_wr with tx_full=1: the word is dropped, err[0]=1, and the read stream shows no duplicate or corruption.
- Assert rst mid-read-burst after 2 words: the next cycle has rxf_n=1, data_oe=0, tx count 0. Pushing X0 afterwards reads back X0 first.
